data_mem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. It accepts the address, write data and write strobe that the memory-write stage drives each cycle, and returns registered read data one cycle later so the data lines up with the register-writeback stage. It also holds 256 words of data RAM and a small memory-mapped I/O page: LEDs, synchronized switches, a free-running cycle counter and a sticky access-error register.

---
 rtl/data_mem_responder.sv | 50 +++++
 tb/tb_data_mem_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: 256-word read-first data RAM plus LED/switch/counter/error MMIO page; clk, rst_n, addr_mem/wdata_mem/write_mem in, rdata_mem (1-cycle registered) out, sw_in in, led_out out
module data_mem_responder #(
  parameter int RAM_WORDS = 256,
  parameter int LED_W     = 10,
  parameter int SW_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       addr_mem,
  input  logic [15:0]      wdata_mem,
  input  logic             write_mem,
  output logic [15:0]      rdata_mem,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out
);
  logic [15:0] ram [RAM_WORDS];
  logic [SW_W-1:0] sw_q1, sw_q2;
  logic [15:0] cnt;
  logic [1:0] err;
  logic is_ram, is_led, is_sw, is_cnt, is_err, is_bad;
  logic [15:0] rd;
  assign is_ram = !addr_mem[8];
  assign is_led = addr_mem == 9'h100;
  assign is_sw  = addr_mem == 9'h140;
  assign is_cnt = addr_mem == 9'h180;
  assign is_err = addr_mem == 9'h1C0;
  assign is_bad = addr_mem[8] && !(is_led || is_sw || is_cnt || is_err);
  assign rd = is_ram ? ram[addr_mem[7:0]] :
              is_led ? 16'(led_out) :
              is_sw  ? 16'(sw_q2) :
              is_cnt ? cnt :
              is_err ? {14'b0, err} : 16'h0000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_mem <= '0;
      led_out   <= '0;
      sw_q1     <= '0;
      sw_q2     <= '0;
      cnt       <= '0;
      err       <= '0;
    end else begin
      if (write_mem && is_ram) ram[addr_mem[7:0]] <= wdata_mem;
      rdata_mem <= rd;
      sw_q1     <= sw_in;
      sw_q2     <= sw_q1;
      led_out   <= (write_mem && is_led) ? wdata_mem[LED_W-1:0] : led_out;
      cnt       <= (write_mem && is_cnt) ? wdata_mem : cnt + 16'd1;
      err       <= (write_mem && is_err) ? 2'b00 : {err[1] | is_bad, err[0] | (write_mem && is_sw)};
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven and directed checks of data_mem_responder
module tb_data_mem_responder;
  logic        clk = 0;
  logic        rst_n;
  logic [8:0]  addr_mem;
  logic [15:0] wdata_mem;
  logic        write_mem;
  logic [15:0] rdata_mem;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  int vectors = 0;
  int miscompares = 0;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .write_mem(write_mem), .rdata_mem(rdata_mem), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
    logic        w;
    logic        chk;
    logic [15:0] exp;
    logic [9:0]  led;
  } vec_t;
  vec_t tbl[28];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [8:0] a, input logic [15:0] d, input logic w);
    addr_mem = a;
    wdata_mem = d;
    write_mem = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h000};
    tbl[1]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0001, 10'h000};
    tbl[2]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0002, 10'h000};
    tbl[3]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0003, 10'h000};
    tbl[4]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0004, 10'h000};
    tbl[5]  = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0005, 10'h000};
    tbl[6]  = '{9'h005, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 10'h000};
    tbl[7]  = '{9'h0FF, 16'h1234, 1'b1, 1'b0, 16'h0000, 10'h000};
    tbl[8]  = '{9'h005, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 10'h000};
    tbl[9]  = '{9'h0FF, 16'h0000, 1'b0, 1'b1, 16'h1234, 10'h000};
    tbl[10] = '{9'h005, 16'h5555, 1'b1, 1'b1, 16'hBEEF, 10'h000};
    tbl[11] = '{9'h005, 16'h0000, 1'b0, 1'b1, 16'h5555, 10'h000};
    tbl[12] = '{9'h100, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 10'h3FF};
    tbl[13] = '{9'h100, 16'h0000, 1'b0, 1'b1, 16'h03FF, 10'h3FF};
    tbl[14] = '{9'h180, 16'hFFFE, 1'b1, 1'b1, 16'h000E, 10'h3FF};
    tbl[15] = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 10'h3FF};
    tbl[16] = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 10'h3FF};
    tbl[17] = '{9'h180, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF};
    tbl[18] = '{9'h123, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF};
    tbl[19] = '{9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0002, 10'h3FF};
    tbl[20] = '{9'h140, 16'h9999, 1'b1, 1'b1, 16'h0000, 10'h3FF};
    tbl[21] = '{9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0003, 10'h3FF};
    tbl[22] = '{9'h1C0, 16'h0000, 1'b1, 1'b1, 16'h0003, 10'h3FF};
    tbl[23] = '{9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF};
    tbl[24] = '{9'h101, 16'hAAAA, 1'b1, 1'b1, 16'h0000, 10'h3FF};
    tbl[25] = '{9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0002, 10'h3FF};
    tbl[26] = '{9'h1C0, 16'h1234, 1'b1, 1'b1, 16'h0002, 10'h3FF};
    tbl[27] = '{9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF};

    rst_n = 0;
    addr_mem = '0;
    wdata_mem = '0;
    write_mem = 0;
    sw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata_mem, 16'h0000);
    check("reset_led", 16'(led_out), 16'h0000);
    #3 rst_n = 1;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].a, tbl[i].d, tbl[i].w);
      if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rdata_mem, tbl[i].exp);
      check($sformatf("vec%0d_led", i), 16'(led_out), 16'(tbl[i].led));
    end

    sw_in = 10'h2A5;
    step(9'h140, 16'h0000, 1'b0);
    check("sw_edge1", rdata_mem, 16'h0000);
    step(9'h140, 16'h0000, 1'b0);
    check("sw_edge2", rdata_mem, 16'h0000);
    step(9'h140, 16'h0000, 1'b0);
    check("sw_edge3", rdata_mem, 16'h02A5);
    step(9'h1C0, 16'h0000, 1'b0);
    check("err_after_sw_reads", rdata_mem, 16'h0000);

    step(9'h100, 16'h03FF, 1'b1);
    step(9'h180, 16'h1000, 1'b1);
    step(9'h005, 16'h7777, 1'b1);
    check("pre_reset_rdata", rdata_mem, 16'h5555);
    check("pre_reset_led", 16'(led_out), 16'h03FF);
    #2 rst_n = 0;
    #1;
    check("async_rdata", rdata_mem, 16'h0000);
    check("async_led", 16'(led_out), 16'h0000);
    addr_mem = 9'h005;
    wdata_mem = 16'hDEAD;
    write_mem = 1;
    @(posedge clk);
    #1;
    check("reset_hold_rdata", rdata_mem, 16'h0000);
    #2 rst_n = 1;
    step(9'h180, 16'h0000, 1'b0);
    check("cnt_after_reset", rdata_mem, 16'h0000);
    step(9'h005, 16'h0000, 1'b0);
    check("ram_write_in_reset", rdata_mem, 16'h7777);
    step(9'h180, 16'h0000, 1'b0);
    check("cnt_after_reset_2", rdata_mem, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
